multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle ARM-subset control FSM with optional memory wait states (MEM_WAIT).
// Define CONDEX_EN to enable conditional execution of Cond against the internal NZCV register.
module multicycle_control #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic        FlagWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  wait_q, wait_d;
    logic [3:0]  nzcv_q, nzcv_d;

    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        wait_done;
    logic        is_cmp;
    logic        cond_ok;
    logic [1:0]  alu_dec;
    logic        pcw_fetch, pcw_raw, rw_raw, mw_raw, fw_raw;

    assign op        = Instr[27:26];
    assign funct     = Instr[25:20];
    assign rd        = Instr[15:12];
    assign wait_done = (wait_q == 3'(MEM_WAIT));
    assign is_cmp    = (funct[4:1] == 4'b1010);

    logic unused_instr;
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

`ifdef CONDEX_EN
    logic n_f, z_f, c_f, v_f;
    assign {n_f, z_f, c_f, v_f} = nzcv_q;

    always_comb begin
        cond_ok = 1'b1;
        case (Instr[31:28])
            4'b0000: cond_ok = z_f;
            4'b0001: cond_ok = ~z_f;
            4'b0010: cond_ok = c_f;
            4'b0011: cond_ok = ~c_f;
            4'b0100: cond_ok = n_f;
            4'b0101: cond_ok = ~n_f;
            4'b0110: cond_ok = v_f;
            4'b0111: cond_ok = ~v_f;
            4'b1000: cond_ok = c_f & ~z_f;
            4'b1001: cond_ok = ~c_f | z_f;
            4'b1010: cond_ok = (n_f == v_f);
            4'b1011: cond_ok = (n_f != v_f);
            4'b1100: cond_ok = ~z_f & (n_f == v_f);
            4'b1101: cond_ok = z_f | (n_f != v_f);
            default: cond_ok = 1'b1;
        endcase
    end
`else
    logic unused_cond;
    assign unused_cond = ^Instr[31:28];
    assign cond_ok     = 1'b1;
`endif

    always_comb begin
        alu_dec = 2'b00;
        case (funct[4:1])
            4'b0100: alu_dec = 2'b00;
            4'b0010: alu_dec = 2'b01;
            4'b0000: alu_dec = 2'b10;
            4'b1100: alu_dec = 2'b11;
            4'b1010: alu_dec = 2'b01;
            default: alu_dec = 2'b00;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            2'b01:   ImmSrc = 2'b01;
            2'b10:   ImmSrc = 2'b10;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign RegSrc = {(op == 2'b01) & ~funct[0], (op == 2'b10)};

    always_comb begin
        state_d    = state_q;
        pcw_fetch  = 1'b0;
        pcw_raw    = 1'b0;
        rw_raw     = 1'b0;
        mw_raw     = 1'b0;
        fw_raw     = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        case (state_q)
            FETCH: begin
                // Wait cycles idle the datapath; only the final cycle latches IR and advances PC.
                if (wait_done) begin
                    state_d   = DECODE;
                    pcw_fetch = 1'b1;
                    IRWrite   = 1'b1;
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = funct[5] ? EXECI : EXECR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
                if (wait_done) state_d = MEMWB;
            end
            MEMWB: begin
                rw_raw    = 1'b1;
                ResultSrc = 2'b01;
                state_d   = FETCH;
            end
            MEMWR: begin
                AdrSrc  = 1'b1;
                mw_raw  = 1'b1;
                state_d = FETCH;
            end
            EXECR: begin
                ALUControl = alu_dec;
                state_d    = ALUWB;
            end
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
                state_d    = ALUWB;
            end
            ALUWB: begin
                rw_raw  = ~is_cmp;
                pcw_raw = ~is_cmp & (rd == 4'd15);
                fw_raw  = funct[0];
                state_d = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pcw_raw   = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // A failed condition squashes architectural writes; the FSM path is unchanged.
        PCWrite   = pcw_fetch | (pcw_raw & cond_ok);
        RegWrite  = rw_raw & cond_ok;
        MemWrite  = mw_raw & cond_ok;
        FlagWrite = fw_raw & cond_ok;

        if (rst) begin
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            FlagWrite  = 1'b0;
            IRWrite    = 1'b0;
            AdrSrc     = 1'b0;
            ALUSrcA    = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcB    = 2'b00;
            ALUControl = 2'b00;
        end
    end

    assign wait_d = (state_d != state_q) ? 3'd0 : wait_q + 3'd1;
    assign nzcv_d = FlagWrite ? ALUFlags : nzcv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            wait_q  <= 3'd0;
            nzcv_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            nzcv_q  <= nzcv_d;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: dut_a (MEM_WAIT=0) walks the instruction classes, dut_b (MEM_WAIT=2) covers wait states and mid-instruction reset.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [31:0] instr_a, instr_b;
    logic [3:0]  alu_flags;

    logic        pcw_a, mw_a, rw_a, irw_a, adr_a, asa_a, fw_a;
    logic [1:0]  rs_a, asb_a, imm_a, rsrc_a, aluc_a;
    logic [3:0]  st_a;
    logic        pcw_b, mw_b, rw_b, irw_b, adr_b, asa_b, fw_b;
    logic [1:0]  rs_b, asb_b, imm_b, rsrc_b, aluc_b;
    logic [3:0]  st_b;

    logic [20:0] exp_q[$];
    logic [20:0] exp2_q[$];
    int          checks = 0;
    int          passes = 0;
    int          cyc_a = 0;
    int          cyc_b = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_WAIT(0)) dut_a (
        .clk(clk), .rst(rst_a), .Instr(instr_a), .ALUFlags(alu_flags),
        .PCWrite(pcw_a), .MemWrite(mw_a), .RegWrite(rw_a), .IRWrite(irw_a),
        .AdrSrc(adr_a), .ALUSrcA(asa_a), .FlagWrite(fw_a), .ResultSrc(rs_a),
        .ALUSrcB(asb_a), .ImmSrc(imm_a), .RegSrc(rsrc_a), .ALUControl(aluc_a),
        .State(st_a)
    );

    multicycle_control #(.MEM_WAIT(2)) dut_b (
        .clk(clk), .rst(rst_b), .Instr(instr_b), .ALUFlags(alu_flags),
        .PCWrite(pcw_b), .MemWrite(mw_b), .RegWrite(rw_b), .IRWrite(irw_b),
        .AdrSrc(adr_b), .ALUSrcA(asa_b), .FlagWrite(fw_b), .ResultSrc(rs_b),
        .ALUSrcB(asb_b), .ImmSrc(imm_b), .RegSrc(rsrc_b), .ALUControl(aluc_b),
        .State(st_b)
    );

    // Strobe field order: PCWrite MemWrite RegWrite IRWrite AdrSrc ALUSrcA FlagWrite
    localparam logic [6:0] Z  = 7'b0000000;
    localparam logic [6:0] FS = 7'b1001010;
    localparam logic [6:0] DS = 7'b0000010;
    localparam logic [6:0] AD = 7'b0000100;
    localparam logic [6:0] RW = 7'b0010000;
    localparam logic [6:0] MW = 7'b0100100;
    localparam logic [6:0] PC = 7'b1000000;
    localparam logic [6:0] PR = 7'b1010000;
    localparam logic [6:0] FW = 7'b0000001;
`ifdef CONDEX_EN
    localparam logic [6:0] NE_RW = 7'b0000000;
`else
    localparam logic [6:0] NE_RW = 7'b0010000;
`endif

    function automatic logic [31:0] mk(input logic [3:0] cond, input logic [1:0] op,
                                       input logic [5:0] funct, input logic [3:0] rd);
        return {cond, op, funct, 4'h0, rd, 12'h000};
    endfunction

    // One cycle of stimulus: drive inputs just after the edge, queue the hand-computed response.
    task automatic cyc(input bit sel_b, input logic r, input logic [31:0] ins,
                       input logic [3:0] st, input logic [6:0] sb,
                       input logic [1:0] rs, input logic [1:0] asb, input logic [1:0] imm,
                       input logic [1:0] rsrc, input logic [1:0] aluc);
        @(posedge clk);
        #1;
        if (sel_b) begin
            rst_b   = r;
            instr_b = ins;
            exp2_q.push_back({st, sb, rs, asb, imm, rsrc, aluc});
        end else begin
            rst_a   = r;
            instr_a = ins;
            exp_q.push_back({st, sb, rs, asb, imm, rsrc, aluc});
        end
    endtask

    always @(negedge clk) begin
        logic [20:0] e, act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {st_a, pcw_a, mw_a, rw_a, irw_a, adr_a, asa_a, fw_a,
                   rs_a, asb_a, imm_a, rsrc_a, aluc_a};
            checks++;
            if (act !== e) $display("FAIL dut_a step %0d: got %h expected %h", cyc_a, act, e);
            else passes++;
            cyc_a++;
        end
        if (exp2_q.size() > 0) begin
            e   = exp2_q.pop_front();
            act = {st_b, pcw_b, mw_b, rw_b, irw_b, adr_b, asa_b, fw_b,
                   rs_b, asb_b, imm_b, rsrc_b, aluc_b};
            checks++;
            if (act !== e) $display("FAIL dut_b step %0d: got %h expected %h", cyc_b, act, e);
            else passes++;
            cyc_b++;
        end
    end

    initial begin
        logic [31:0] addi, ldr, str, br, andi, orr15, cmp, addne, addeq, undef;
        addi  = mk(4'b1110, 2'b00, 6'b101000, 4'd1);
        ldr   = mk(4'b1110, 2'b01, 6'b011001, 4'd2);
        str   = mk(4'b1110, 2'b01, 6'b011000, 4'd2);
        br    = mk(4'b1110, 2'b10, 6'b100000, 4'd0);
        andi  = mk(4'b1110, 2'b00, 6'b100000, 4'd3);
        orr15 = mk(4'b1110, 2'b00, 6'b011000, 4'd15);
        cmp   = mk(4'b1110, 2'b00, 6'b010101, 4'd0);
        addne = mk(4'b0001, 2'b00, 6'b101000, 4'd4);
        addeq = mk(4'b0000, 2'b00, 6'b101000, 4'd5);
        undef = mk(4'b1110, 2'b11, 6'b000000, 4'd0);

        rst_a = 1'b1; rst_b = 1'b1;
        instr_a = 32'd0; instr_b = 32'd0;
        alu_flags = 4'b0100;

        // Reset held, then ADD immediate
        cyc(0, 1, 32'd0, 4'd0, Z,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        cyc(0, 1, 32'd0, 4'd0, Z,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        cyc(0, 0, addi,  4'd0, FS, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        cyc(0, 0, addi,  4'd1, DS, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        cyc(0, 0, addi,  4'd7, Z,  2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        cyc(0, 0, addi,  4'd8, RW, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        // LDR
        cyc(0, 0, ldr, 4'd0, FS, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00);
        cyc(0, 0, ldr, 4'd1, DS, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00);
        cyc(0, 0, ldr, 4'd2, Z,  2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
        cyc(0, 0, ldr, 4'd3, AD, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        cyc(0, 0, ldr, 4'd4, RW, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        // STR
        cyc(0, 0, str, 4'd0, FS, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00);
        cyc(0, 0, str, 4'd1, DS, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00);
        cyc(0, 0, str, 4'd2, Z,  2'b00, 2'b01, 2'b01, 2'b10, 2'b00);
        cyc(0, 0, str, 4'd5, MW, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00);
        // B
        cyc(0, 0, br, 4'd0, FS, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00);
        cyc(0, 0, br, 4'd1, DS, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00);
        cyc(0, 0, br, 4'd9, PC, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00);
        // AND immediate
        cyc(0, 0, andi, 4'd0, FS, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        cyc(0, 0, andi, 4'd1, DS, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        cyc(0, 0, andi, 4'd7, Z,  2'b00, 2'b01, 2'b00, 2'b00, 2'b10);
        cyc(0, 0, andi, 4'd8, RW, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        // ORR register into R15 also writes PC
        cyc(0, 0, orr15, 4'd0, FS, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        cyc(0, 0, orr15, 4'd1, DS, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        cyc(0, 0, orr15, 4'd6, Z,  2'b00, 2'b00, 2'b00, 2'b00, 2'b11);
        cyc(0, 0, orr15, 4'd8, PR, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        // CMP sets Z from ALUFlags=0100
        cyc(0, 0, cmp, 4'd0, FS, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        cyc(0, 0, cmp, 4'd1, DS, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        cyc(0, 0, cmp, 4'd6, Z,  2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
        cyc(0, 0, cmp, 4'd8, FW, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        // ADDNE with Z=1, then ADDEQ
        cyc(0, 0, addne, 4'd0, FS,    2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        cyc(0, 0, addne, 4'd1, DS,    2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        cyc(0, 0, addne, 4'd7, Z,     2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        cyc(0, 0, addne, 4'd8, NE_RW, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        cyc(0, 0, addeq, 4'd0, FS,    2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        cyc(0, 0, addeq, 4'd1, DS,    2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        cyc(0, 0, addeq, 4'd7, Z,     2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        cyc(0, 0, addeq, 4'd8, RW,    2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        // Undefined Op=11 returns to FETCH
        cyc(0, 0, undef, 4'd0, FS, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        cyc(0, 0, undef, 4'd1, DS, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        cyc(0, 0, undef, 4'd0, FS, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);

        // MEM_WAIT=2: LDR interrupted by reset in MEMRD, then a full LDR
        cyc(1, 1, ldr, 4'd0, Z,  2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        cyc(1, 0, ldr, 4'd0, Z,  2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        cyc(1, 0, ldr, 4'd0, Z,  2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        cyc(1, 0, ldr, 4'd0, FS, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00);
        cyc(1, 0, ldr, 4'd1, DS, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00);
        cyc(1, 0, ldr, 4'd2, Z,  2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
        cyc(1, 1, ldr, 4'd3, Z,  2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        cyc(1, 0, ldr, 4'd0, Z,  2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        cyc(1, 0, ldr, 4'd0, Z,  2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        cyc(1, 0, ldr, 4'd0, FS, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00);
        cyc(1, 0, ldr, 4'd1, DS, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00);
        cyc(1, 0, ldr, 4'd2, Z,  2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
        cyc(1, 0, ldr, 4'd3, AD, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        cyc(1, 0, ldr, 4'd3, AD, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        cyc(1, 0, ldr, 4'd3, AD, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        cyc(1, 0, ldr, 4'd4, RW, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        cyc(1, 0, ldr, 4'd0, Z,  2'b00, 2'b00, 2'b01, 2'b00, 2'b00);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() + exp2_q.size() != 0)
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size() + exp2_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
